// File: rtl/clkgate_pkg.sv
// ============================================================================
// Module      : clkgate_pkg
// Description : Shared types for the clock-gating controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clkgate_pkg;

    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_GATED = 2'd1,
        CG_WAKE  = 2'd2
    } cg_state_e;

    localparam cg_state_e CG_RST_STATE = CG_RUN;

endpackage

`default_nettype wire

// File: rtl/clkgate_cell.sv
// ============================================================================
// Module      : clkgate_cell
// Description : Latch-based glitch-free clock gate with test override.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkgate_cell (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_i,
    output logic gclk_o
);

    logic r_en_lat;

    // Enable is captured only while the clock is low so gclk never glitches.
    always_latch begin
        if (!clk_i) begin
            r_en_lat <= en_i | test_i;
        end
    end

    assign gclk_o = clk_i & r_en_lat;

endmodule

`default_nettype wire

// File: rtl/clkgate_ch.sv
// ============================================================================
// Module      : clkgate_ch
// Description : One channel's gating FSM with idle hysteresis and wake delay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkgate_ch
    import clkgate_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int WAKE_DLY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en_i,
    input  logic             busy_i,
    input  logic             wake_req_i,
    input  logic [CNT_W-1:0] thr_i,
    output logic             en_q_o,
    output logic             gated_o,
    output logic             wake_ack_o
);

    localparam logic [CNT_W-1:0] c_wake_dly = CNT_W'(WAKE_DLY);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    cg_state_e        state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic             en_q, gated_q, ack_q;
    logic             w_idle;

    assign w_idle = cfg_en_i & ~busy_i & ~wake_req_i & (thr_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CG_RST_STATE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            en_q       <= 1'b1;
            gated_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            en_q       <= (state_d != CG_GATED);
            gated_q    <= (state_d == CG_GATED);
            ack_q      <= (state_q == CG_RUN) & wake_req_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        case (state_q)
            CG_RUN: begin
                if (!w_idle) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == thr_i - c_one) begin
                    state_d    = CG_GATED;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + c_one;
                end
            end
            CG_GATED: begin
                if (wake_req_i | busy_i | ~cfg_en_i) begin
                    state_d    = CG_WAKE;
                    wake_cnt_d = c_wake_dly;
                end
            end
            CG_WAKE: begin
                // Wake always runs to completion regardless of inputs.
                if (wake_cnt_q == c_one) begin
                    state_d    = CG_RUN;
                    idle_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q - c_one;
                end
            end
            default: begin
                state_d    = CG_RST_STATE;
                idle_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        en_q_o     = en_q;
        gated_o    = gated_q;
        wake_ack_o = ack_q;
    end

endmodule

`default_nettype wire

// File: rtl/clkgate_ctrl.sv
// ============================================================================
// Module      : clkgate_ctrl
// Description : Multi-channel automatic clock-gating controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkgate_ctrl
    import clkgate_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int WAKE_DLY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_en,
    input  logic [NUM_CH-1:0] cfg_en,
    input  logic [CNT_W-1:0]  cfg_idle_thr,
    input  logic [NUM_CH-1:0] busy,
    input  logic [NUM_CH-1:0] wake_req,
    output logic [NUM_CH-1:0] wake_ack,
    output logic [NUM_CH-1:0] gated,
    output logic [NUM_CH-1:0] gclk
);

    logic [NUM_CH-1:0] w_en;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkgate_ch #(
            .CNT_W    (CNT_W),
            .WAKE_DLY (WAKE_DLY)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .cfg_en_i   (cfg_en[i]),
            .busy_i     (busy[i]),
            .wake_req_i (wake_req[i]),
            .thr_i      (cfg_idle_thr),
            .en_q_o     (w_en[i]),
            .gated_o    (gated[i]),
            .wake_ack_o (wake_ack[i])
        );

        clkgate_cell u_cell (
            .clk_i  (clk),
            .en_i   (w_en[i]),
            .test_i (test_en),
            .gclk_o (gclk[i])
        );
    end

endmodule

`default_nettype wire

// File: doc/clkgate_ctrl.md
Name: clkgate_ctrl

Overview:
- Multi-channel automatic clock-gating controller. NUM_CH gated clocks are derived from one root clock.
- Each channel has a registered enable driven by a per-channel FSM with three functions:
  - idle-count hysteresis: the clock is gated after a programmable number of consecutive idle cycles;
  - wake-delay: the clock runs for WAKE_DLY cycles before the requester is acknowledged;
  - a 4-phase wake_req/wake_ack handshake.
- The block sits between the power-management CSRs and the leaf clock domains. Each output passes through the team's latch-based clkgate cell.

Parameters:
- NUM_CH, 4, number of independently gated channels (≥1).
- CNT_W, 8, width of the idle-threshold and internal counters.
- WAKE_DLY, 2, cycles the clock runs in WAKE before the channel returns to RUN (1..2^CNT_W-1).

Ports:
- clk  in  1  root clock.
- rst  in  1  synchronous, active-high reset.
- test_en  in  1  scan/test override: forces all gate cells open.
- cfg_en  in  NUM_CH  per-channel auto-gating enable.
- cfg_idle_thr  in  CNT_W  idle cycles required before gating; 0 = never gate. Shared by all channels.
- busy  in  NUM_CH  domain activity indication, synchronous to clk.
- wake_req  in  NUM_CH  wake request, level, held until wake_ack.
- wake_ack  out  NUM_CH  wake acknowledge, level, registered.
- gated  out  NUM_CH  registered status: 1 while the channel FSM is in GATED.
- gclk  out  NUM_CH  gated clock outputs.

Behaviour:
- Per-channel FSM states: RUN, GATED, WAKE. Registered enable en_q = (state != GATED).
- Gate-cell enable = en_q; test_en is passed to the cell's test input. gclk[i] is clk gated by that cell (glitch-free, transparent while clk low).
- Reset (sync, rst high at edge): every channel goes to RUN, en_q=1, idle_cnt=0, wake_ack=0, gated=0. gclk runs from the first edge with rst sampled high. Reset mid-WAKE or mid-GATED returns the channel to RUN the same way.
- RUN:
  - Idle cycle = cfg_en & !busy & !wake_req & (cfg_idle_thr != 0).
  - Non-idle cycle: idle_cnt <= 0.
  - Idle cycle with idle_cnt == cfg_idle_thr-1: go to GATED, idle_cnt <= 0.
  - Otherwise on an idle cycle: idle_cnt <= idle_cnt+1.
  - Net effect: gating occurs at the edge that ends the cfg_idle_thr-th consecutive idle cycle. gclk stops from the following low phase.
- GATED: if wake_req | busy | !cfg_en, go to WAKE and load wake_cnt <= WAKE_DLY. en_q rises at that same edge.
- WAKE:
  - wake_cnt decrements each cycle. At the edge where wake_cnt == 1, go to RUN with idle_cnt=0.
  - busy, cfg_en and wake_req have no effect during WAKE; it always completes.
- Wake timing: a request sampled at edge k in GATED gives RUN at edge k+WAKE_DLY.
- wake_ack: registered; next value = (state==RUN) & wake_req.
  - Rises at edge k+WAKE_DLY+1 after a wake from GATED.
  - One edge after wake_req if the channel is already in RUN.
  - Falls one edge after wake_req falls.
  - A requester must not deassert wake_req before seeing wake_ack. If it does, the wake still completes and ack stays low.
- cfg_idle_thr change: takes effect on the next compare. If the new value is ≤ the current idle_cnt, the channel waits for idle_cnt to wrap; this is accepted behaviour. Software changes the threshold only with cfg_en low.
- Counter widths: idle_cnt and wake_cnt are CNT_W bits, with no saturation needed given the rules above.
- test_en: all gclk toggle continuously. FSM, gated and wake_ack behave exactly as without test_en.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Simultaneous busy and wake_req in GATED: single transition to WAKE.

Decomposition:
- Package clkgate_pkg:
  - enum cg_state_e {CG_RUN, CG_GATED, CG_WAKE}, 2 bits;
  - localparam CG_RST_STATE = CG_RUN.
- Sub-module clkgate_ch: one channel's FSM and counters. Outputs en_q, gated and wake_ack; inputs cfg_en, busy, wake_req, thr.
- clkgate_ctrl contains a generate loop with one clkgate_ch plus one clkgate cell per channel.

Test Plan:
- Reset, thr=4, cfg_en=1, busy=0, no wake_req → gated rises at the 4th edge after rst falls; gclk stops afterwards, others unaffected.
- thr=4, busy pulses every 3 cycles → gated never rises; the counter restarts on each pulse.
- Channel gated, WAKE_DLY=2, wake_req at edge k → gclk resumes from edge k, gated falls at k, RUN at k+2, wake_ack at k+3. Drop wake_req → wake_ack low one edge later.
- thr=0 or cfg_en=0 with busy=0 for 300 cycles → never gated. Clear cfg_en while gated → WAKE, then RUN after WAKE_DLY with no wake_ack.
- test_en=1 with channel in GATED → gclk toggles every cycle, gated remains 1. test_en=0 → gclk stops again.
- rst asserted during WAKE on ch0 and GATED on ch1 → both RUN, wake_ack=0, gated=0, gclk running from the reset edge.
